// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: shares one backpressured output stage between
// NUM_REQ requesters, optionally holding the grant for a whole packet.
module stream_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATAW    = 8,
    parameter int unsigned LOCK_PKT = 1,
    localparam int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0][DATAW-1:0]   data_i,
    input  logic [NUM_REQ-1:0]              valid_i,
    input  logic [NUM_REQ-1:0]              last_i,
    output logic [NUM_REQ-1:0]              ready_o,
    output logic [DATAW-1:0]                data_o,
    output logic                            valid_o,
    output logic                            last_o,
    output logic [IDXW-1:0]                 idx_o,
    input  logic                            ready_i
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [IDXW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IDXW-1:0]   lock_idx_q, lock_idx_d;

    logic              stage_ready;
    logic              grant_vld;
    logic [IDXW-1:0]   grant_idx;
    logic              fire;

    // (base + off) mod NUM_REQ; both operands are already below NUM_REQ
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDXW'(sum);
    endfunction

    // Output stage can take a new beat when empty or when being drained
    assign stage_ready = ready_i || !valid_o;

    // Grant selection: locked owner, else first valid from rr_ptr onwards
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == ST_LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && valid_i[wrap_add(rr_ptr_q, i)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap_add(rr_ptr_q, i);
                end
            end
        end
    end

    // Only the granted requester sees ready, gated by the output stage
    always_comb begin
        ready_o = '0;
        if (grant_vld) begin
            ready_o[grant_idx] = stage_ready;
        end
    end

    assign fire = grant_vld && valid_i[grant_idx] && stage_ready;

    // Next-state logic for packet lock and round-robin pointer
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (fire) begin
            case (state_q)
                ST_IDLE: begin
                    if ((LOCK_PKT != 0) && !last_i[grant_idx]) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant_idx;
                    end else begin
                        rr_ptr_d = wrap_add(grant_idx, 1);
                    end
                end
                ST_LOCKED: begin
                    if (last_i[grant_idx]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(lock_idx_q, 1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Output register stage; holds everything while stalled downstream
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            idx_o   <= '0;
        end else if (stage_ready) begin
            valid_o <= fire;
            if (fire) begin
                data_o <= data_i[grant_idx];
                last_o <= last_i[grant_idx];
                idx_o  <= grant_idx;
            end
        end
    end

endmodule
